axi_wr_burst_guard: RTL
=======================

Name: axi_wr_burst_guard

Overview:
- Sits directly downstream of the cache subsystem's arbitrated AXI master port, between it and the SoC interconnect.
- Guarantees that no W beat reaches the interconnect before its AW is accepted.
- Caps outstanding write bursts at MaxOutstanding, counted from AW handshake to B handshake.
- Regenerates w.last from the recorded AW len and flags any mismatch in the upstream w.last.
- AR, R and B pass through combinationally; only AW and W are gated.

Parameters:
- MaxOutstanding, 4, maximum write bursts in flight (AW accepted, B not yet accepted); must be ≥1.
- CntWidth, $clog2(MaxOutstanding+1), width of the outstanding counter (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- slv_req_i  in  ariane_axi::req_t  request from cache subsystem
- slv_resp_o  out  ariane_axi::resp_t  response to cache subsystem
- mst_req_o  out  ariane_axi::req_t  request to interconnect
- mst_resp_i  in  ariane_axi::resp_t  response from interconnect
- outstanding_o  out  CntWidth  current outstanding write bursts
- idle_o  out  1  high when outstanding_o==0, len FIFO empty and beat counter zero
- w_len_err_o  out  1  sticky; set on upstream w.last mismatch

Behaviour:
- Reset: one clock, synchronous, active-high on rst_i, sampled at the clk_i edge.
  - Clears the outstanding counter, len FIFO, beat counter and w_len_err_o.
  - After reset: outstanding_o=0, idle_o=1, w_len_err_o=0.
  - All gated valids/readies are 0 while rst_i is high.
  - A reset mid-burst abandons all tracking. No beats are replayed.
- Pass-through (combinational, zero latency): ar, ar_valid, ar_ready, r, r_valid, r_ready, b, b_valid, b_ready.
- AW gating:
  - full = (outstanding==MaxOutstanding).
  - mst aw_valid = slv aw_valid & ~full.
  - slv aw_ready = mst aw_ready & ~full.
  - aw payload is forwarded unchanged.
  - AW handshake (mst side) increments outstanding and pushes aw.len (8 bit) into the len FIFO (depth MaxOutstanding).
- B accounting:
  - A B handshake decrements outstanding.
  - Simultaneous AW and B handshakes leave the count unchanged.
  - Because decrement and increment in the same cycle net to zero, AW remains blocked while full even if B completes that cycle. Unblocking occurs the cycle after.
  - A B handshake with outstanding==0 is ignored: the counter saturates at 0.
- W gating:
  - W is enabled only when the len FIFO is non-empty. There is no same-cycle AW→W bypass: the first W beat leaves at least one cycle after its AW handshake.
  - mst w_valid = slv w_valid & ~fifo_empty.
  - slv w_ready = mst w_ready & ~fifo_empty.
  - data, strb and user are forwarded unchanged.
- Beat counter (8 bit):
  - Counts accepted beats of the head burst.
  - mst w.last = (beat_cnt == head_len), regardless of upstream w.last.
  - A W handshake with mst w.last=1 pops the FIFO and clears beat_cnt. Otherwise beat_cnt increments.
- Error detection: on any W handshake, if slv w.last != generated last, w_len_err_o sets and stays set until reset. Forwarding continues using the generated last.
- FIFO boundary cases:
  - Push while full cannot occur, because AW is blocked when outstanding==MaxOutstanding and FIFO entries ≤ outstanding.
  - Push and pop in the same cycle are allowed at any occupancy.
- Combinational paths:
  - outstanding_o is registered.
  - idle_o is combinational from registered state only.
  - No combinational path exists from mst_resp_i.aw_ready to mst_req_o.w_valid.

Test Plan:
- Single write, len=3, W offered in the same cycle as AW → W held one cycle; 4 beats forwarded with last on beat 4 only; B returns → outstanding 1→0, idle_o=1, w_len_err_o=0.
- MaxOutstanding=4, 5 back-to-back AWs with B withheld → 4 accepted, 5th aw_ready=0, outstanding_o=4. B then accepted in the same cycle the 5th AW is offered → 5th accepted the next cycle, outstanding stays 4.
- Upstream sends len=1 with w.last on beat 1 → mst w.last appears on beat 2, w_len_err_o=1 and stays 1 after further clean bursts, until rst_i.
- Interleaved AR/R traffic during a blocked AW → AR/R handshakes unaffected, zero added latency, data bit-exact.
- Three AWs with lens 0, 7, 2 issued before any W → FIFO orders the bursts; lasts appear on beats 1, 9 and 12 of the W stream; the FIFO is empty afterwards.
- rst_i asserted mid-burst (beat 3 of 8, outstanding=2) → next cycle outstanding_o=0, idle_o=1, w_valid=0. A new AW len=0 then completes normally.

Source files
------------

// File: rtl/axi_wr_burst_guard.sv
// AXI write-burst guard between the cache master port and the interconnect.
// Ports: clk_i/rst_i; slv_req_i/slv_resp_o face the cache subsystem,
// mst_req_o/mst_resp_i face the interconnect; outstanding_o counts bursts
// in flight, idle_o flags empty tracking state, w_len_err_o is a sticky
// upstream w.last mismatch flag.

package ariane_axi;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      logic        user;
   } aw_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic        user;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
      logic       user;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic        user;
   } ar_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

module axi_wr_burst_guard #(
   parameter  int unsigned MaxOutstanding = 4,
   localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  ariane_axi::req_t    slv_req_i,
   output ariane_axi::resp_t   slv_resp_o,
   output ariane_axi::req_t    mst_req_o,
   input  ariane_axi::resp_t   mst_resp_i,
   output logic [CntWidth-1:0] outstanding_o,
   output logic                idle_o,
   output logic                w_len_err_o
);

   localparam int unsigned PtrWidth =
      (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
   localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);
   localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] fill_q, fill_d;
   logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]          len_q [MaxOutstanding];
   logic [7:0]          beat_q;
   logic                err_q;

   logic full, fifo_empty, gen_last;
   logic aw_hs, w_hs, b_hs, pop;

   assign full       = (cnt_q == CntMax);
   assign fifo_empty = (fill_q == '0);
   assign gen_last   = (beat_q == len_q[rd_ptr_q]);

   // Everything passes through; only AW/W handshakes and w.last are touched.
   // W gating looks only at registered FIFO state, so aw_ready never
   // reaches w_valid combinationally.
   always_comb begin
      mst_req_o           = slv_req_i;
      slv_resp_o          = mst_resp_i;
      mst_req_o.aw_valid  = slv_req_i.aw_valid & ~full & ~rst_i;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~full & ~rst_i;
      mst_req_o.w_valid   = slv_req_i.w_valid & ~fifo_empty & ~rst_i;
      slv_resp_o.w_ready  = mst_resp_i.w_ready & ~fifo_empty & ~rst_i;
      mst_req_o.w.last    = gen_last;
   end

   assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign w_hs  = mst_req_o.w_valid & mst_resp_i.w_ready;
   assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
   assign pop   = w_hs & gen_last;

   // A B with nothing outstanding is dropped so the count floors at zero.
   always_comb begin
      cnt_d = cnt_q;
      unique case ({aw_hs, b_hs & (cnt_q != '0)})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      fill_d = fill_q;
      unique case ({aw_hs, pop})
         2'b10:   fill_d = fill_q + CntOne;
         2'b01:   fill_d = fill_q - CntOne;
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         fill_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         fill_q <= fill_d;
         if (aw_hs) begin
            wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
         end
         if (w_hs) begin
            beat_q <= gen_last ? 8'd0 : beat_q + 8'd1;
            if (slv_req_i.w.last != gen_last) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Len storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (aw_hs) begin
         len_q[wr_ptr_q] <= slv_req_i.aw.len;
      end
   end

   assign outstanding_o = cnt_q;
   assign idle_o        = (cnt_q == '0) & fifo_empty & (beat_q == 8'd0);
   assign w_len_err_o   = err_q;

endmodule
